// File: rtl/card_dealer.sv
// Blackjack card dealer: draws rank nibbles from an LFSR, tracks a 52-card deck
// with 13 per-rank counters, and falls back to a deterministic scan after MAX_TRIES misses.

module card_dealer_rank (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic       take,
  output logic [2:0] count
);
  always_ff @(posedge clk) begin
    if (reset || refill) count <= 3'd4;
    else if (take)       count <= count - 3'd1;
  end
endmodule

module card_dealer #(
  parameter int MAX_TRIES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rnd_in,
  output logic       rnd_enable,
  input  logic       deal_req,
  input  logic       new_deck,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_points,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy,
  output logic       deal_err
);
  localparam int NUM_RANKS = 13;

  typedef enum logic [1:0] {IDLE, DRAW, SCAN} state_t;

  state_t state_q, state_d;
  logic [7:0] tries_q, tries_d;
  logic [3:0] idx_q, idx_d;
  logic [NUM_RANKS-1:0][2:0] counts;
  logic [NUM_RANKS-1:0] take_vec;
  logic [15:0] avail;
  logic [3:0] cand, cand_pts;
  logic take, refill, valid_d, err_d;

  genvar g;
  generate
    for (g = 0; g < NUM_RANKS; g++) begin : g_rank
      assign take_vec[g] = take && (cand == 4'(g + 1));
      card_dealer_rank u_rank (
        .clk    (clk),
        .reset  (reset),
        .refill (refill),
        .take   (take_vec[g]),
        .count  (counts[g])
      );
    end
  endgenerate

  // avail is indexed by rank; entries 0, 14 and 15 are never dealable
  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_RANKS; i++) avail[i+1] = (counts[i] != 3'd0);
  end

  assign cand = (state_q == SCAN) ? idx_q : rnd_in;

  always_comb begin
    if (cand == 4'd1)      cand_pts = 4'd11;
    else if (cand > 4'd10) cand_pts = 4'd10;
    else                   cand_pts = cand;
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    idx_d   = idx_q;
    take    = 1'b0;
    refill  = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (new_deck) refill = 1'b1;
        else if (deal_req) begin
          if (deck_empty) err_d = 1'b1;
          else begin
            tries_d = 8'd0;
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (new_deck) begin
          refill  = 1'b1;
          state_d = IDLE;
        end else if (avail[cand]) begin
          take    = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (tries_q == 8'(MAX_TRIES - 1)) begin
          idx_d   = 4'd1;
          state_d = SCAN;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      SCAN: begin
        if (new_deck) begin
          refill  = 1'b1;
          state_d = IDLE;
        end else if (avail[cand]) begin
          take    = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tries_q     <= 8'd0;
      idx_q       <= 4'd0;
      card_valid  <= 1'b0;
      deal_err    <= 1'b0;
      card_rank   <= 4'd0;
      card_points <= 4'd0;
      cards_left  <= 6'd52;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      idx_q      <= idx_d;
      card_valid <= valid_d;
      deal_err   <= err_d;
      if (take) begin
        card_rank   <= cand;
        card_points <= cand_pts;
      end
      if (refill)    cards_left <= 6'd52;
      else if (take) cards_left <= cards_left - 6'd1;
    end
  end

  assign rnd_enable = (state_q == DRAW);
  assign busy       = (state_q != IDLE);
  assign deck_empty = (cards_left == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Randomized self-checking bench for card_dealer against a deck-level reference model.

module tb_card_dealer;
  localparam int MAXT = 32;

  logic       clk = 1'b0;
  logic       reset, deal_req, new_deck;
  logic [3:0] rnd_in;
  logic       rnd_enable, card_valid, deck_empty, busy, deal_err;
  logic [3:0] card_rank, card_points;
  logic [5:0] cards_left;

  int n_cmp = 0;
  int n_err = 0;
  int rem [1:13];
  int left;
  int tally [0:15];

  card_dealer #(.MAX_TRIES(MAXT)) dut (
    .clk         (clk),
    .reset       (reset),
    .rnd_in      (rnd_in),
    .rnd_enable  (rnd_enable),
    .deal_req    (deal_req),
    .new_deck    (new_deck),
    .card_valid  (card_valid),
    .card_rank   (card_rank),
    .card_points (card_points),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .busy        (busy),
    .deal_err    (deal_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_full();
    for (int r = 1; r <= 13; r++) rem[r] = 4;
    left = 52;
  endtask

  // mode < 0: random nibbles every cycle; otherwise rnd_in held at mode
  task automatic deal(input int mode);
    int seq [MAXT];
    int er, ek, k, en, ep;
    for (int j = 0; j < MAXT; j++) seq[j] = (mode < 0) ? int'($urandom_range(0, 15)) : mode;
    er = 0; ek = 0;
    for (int j = 0; j < MAXT; j++)
      if (er == 0 && seq[j] >= 1 && seq[j] <= 13 && rem[seq[j]] > 0) begin
        er = seq[j]; ek = j + 1;
      end
    // fallback walks ranks upward, one cycle per rank index
    for (int r = 1; r <= 13; r++)
      if (er == 0 && rem[r] > 0) begin
        er = r; ek = MAXT + r;
      end
    rem[er]--;
    left--;
    ep = (er == 1) ? 11 : (er > 10) ? 10 : er;

    deal_req = 1'b1;
    rnd_in   = 4'(seq[0]);
    step();
    deal_req = 1'b0;
    k = 0; en = 0;
    for (int c = 1; c <= MAXT + 14 && k == 0; c++) begin
      rnd_in = (c <= MAXT) ? 4'(seq[c-1]) : 4'($urandom);
      if (rnd_enable) en++;
      step();
      if (card_valid) k = c;
    end
    chk("latency", k, ek);
    chk("rank", card_rank, er);
    chk("points", card_points, ep);
    chk("cards_left", cards_left, left);
    chk("rnd_enable_cycles", en, (ek < MAXT) ? ek : MAXT);
    tally[card_rank]++;
    step();
    chk("valid_pulse", card_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; deal_req = 1'b0; new_deck = 1'b0; rnd_in = 4'd0;
    for (int i = 0; i < 16; i++) tally[i] = 0;
    model_full();
    step(); step();
    reset = 1'b0;
    chk("rst_left", cards_left, 52);
    chk("rst_empty", deck_empty, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", rnd_enable, 0);
    chk("rst_err", deal_err, 0);
    chk("rst_rank", card_rank, 0);
    chk("rst_pts", card_points, 0);

    // single deal and point mapping
    deal(5);
    deal(1);
    deal(12);
    deal(10);
    // out-of-range nibbles force the scan path
    deal(0);
    deal(14);
    deal(15);

    // rank exhaustion on a fresh deck
    new_deck = 1'b1; step(); new_deck = 1'b0;
    model_full();
    chk("nd_left", cards_left, 52);
    for (int i = 0; i < 5; i++) deal(7);
    chk("exh_rank", card_rank, 1);
    chk("exh_left", cards_left, 47);

    // full deck with random nibbles
    new_deck = 1'b1; step(); new_deck = 1'b0;
    model_full();
    for (int i = 0; i < 16; i++) tally[i] = 0;
    for (int i = 0; i < 52; i++) deal(-1);
    for (int r = 1; r <= 13; r++) chk($sformatf("tally_r%0d", r), tally[r], 4);
    chk("empty_flag", deck_empty, 1);
    chk("empty_left", cards_left, 0);
    deal_req = 1'b1; rnd_in = 4'd3; step(); deal_req = 1'b0;
    chk("err_pulse", deal_err, 1);
    chk("err_valid", card_valid, 0);
    chk("err_busy", busy, 0);
    step();
    chk("err_one_cycle", deal_err, 0);
    chk("err_no_valid", card_valid, 0);

    // new_deck aborting a draw
    new_deck = 1'b1; step(); new_deck = 1'b0;
    model_full();
    deal(-1);
    rnd_in = 4'd0; deal_req = 1'b1; step(); deal_req = 1'b0;
    chk("abort_draw_busy", busy, 1);
    step(); step();
    new_deck = 1'b1; step(); new_deck = 1'b0;
    model_full();
    chk("abort_valid", card_valid, 0);
    chk("abort_left", cards_left, 52);
    chk("abort_busy", busy, 0);
    chk("abort_en", rnd_enable, 0);

    // new_deck beats deal_req in IDLE
    deal(-1);
    deal_req = 1'b1; new_deck = 1'b1; step(); deal_req = 1'b0; new_deck = 1'b0;
    model_full();
    chk("coll_busy", busy, 0);
    chk("coll_left", cards_left, 52);
    chk("coll_en", rnd_enable, 0);
    step();
    chk("coll_valid", card_valid, 0);

    // reset beats new_deck
    deal(13);
    reset = 1'b1; new_deck = 1'b1; step(); reset = 1'b0; new_deck = 1'b0;
    model_full();
    chk("rstnd_left", cards_left, 52);
    chk("rstnd_rank", card_rank, 0);
    chk("rstnd_pts", card_points, 0);
    chk("rstnd_busy", busy, 0);
    chk("rstnd_valid", card_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
